max_finder_pipe: RTL and testbench
==================================

// Module: max_finder_pipe
// PURPOSE
//   Pipelined, handshaked successor to the combinational max tree. It accepts one vector of
//   NUM_INPUTS words per cycle and returns the max (or min) element plus its index. One
//   register stage per tree level gives a fixed latency. It sits between streaming producers
//   (e.g. score/peak units) and consumers that may apply backpressure.
// PARAMETERS
//   WIDTH       8  element width in bits (>=1)
//   NUM_INPUTS  4  elements per vector (>=1)
//   SIGNED      1  1: two's-complement compare; 0: unsigned compare
//   LEVELS      derived = (NUM_INPUTS==1) ? 1 : $clog2(NUM_INPUTS); not user-settable
//   IDX_W       derived = (NUM_INPUTS==1) ? 1 : $clog2(NUM_INPUTS)
// PORTS
//   clk        in   1                  clock, all state on rising edge
//   rst_n      in   1                  asynchronous active-low reset
//   in_valid   in   1                  input vector valid
//   in_ready   out  1                  block can accept a vector this cycle
//   in_min     in   1                  per-vector mode: 0 = find max, 1 = find min
//   inputs     in   WIDTH x NUM_INPUTS unpacked array of elements, inputs[0..NUM_INPUTS-1]
//   out_valid  out  1                  result valid
//   out_ready  in   1                  consumer accepts result
//   out_value  out  WIDTH              selected element (max or min)
//   out_index  out  IDX_W              index of selected element in the input vector
// BEHAVIOUR
//   - Reset (rst_n low, async assert, sync release): out_valid=0, out_value=0, out_index=0,
//     every internal stage valid=0. In-flight vectors are dropped and no result is emitted.
//     Data registers may clear or not; only valid bits matter.
//   - Global advance: adv = !out_valid | out_ready. in_ready = adv (combinational, no
//     dependence on in_valid). When adv=1, all stages shift one level. When adv=0, all stages
//     hold, including data, index, mode and valid.
//   - Accept: transfer occurs when in_valid & in_ready. Each accepted vector gives exactly one
//     result LEVELS cycles later if out_ready stays high. Throughput is 1 vector/cycle.
//   - Tree level k: pair elements (2i, 2i+1). The winner carries its value and original index.
//     An odd trailing element passes through unchanged with its index. The mode bit travels
//     with the data through every stage.
//   - Compare: max mode picks the left (lower index) element when left >= right. Min mode picks
//     left when left <= right. Ties therefore always resolve to the lowest index.
//   - SIGNED=1 compares as signed and SIGNED=0 as unsigned. There is no width growth, and
//     out_value is a bit-exact copy of an input element.
//   - NUM_INPUTS=1: one register stage. out_value=inputs[0], out_index=0.
//   - Output registers hold stable while out_valid & !out_ready (AXI-style; no change until
//     accepted).
//   - Bubbles (in_valid=0 while adv=1) propagate as invalid stages. They are not collapsed.
//   - Simultaneous accept and emit in the same cycle is legal and required for full rate.
//   - in_min, inputs and in_valid are don't-care when in_ready=0 or in_valid=0.
// TESTING
//   1 W=8,N=4,S=1: {3,-7,12,12} max, out_ready=1 -> after 2 cycles value=12, index=2.
//   2 Same vector with in_min=1 -> value=-7, index=1. With S=0 the same bits 0xF9 give
//     min value=3, index=0.
//   3 N=5: {1,9,4,2,20} then {30,0,0,0,0} back-to-back, max -> 20/idx4, then 30/idx0 on
//     consecutive cycles.
//   4 Backpressure: stream 6 vectors, hold out_ready=0 for 4 cycles mid-stream ->
//     in_ready=0 while out_valid & !out_ready. Output stays stable. All 6 results arrive
//     in order with none lost or duplicated.
//   5 Reset mid-operation: assert rst_n=0 with 2 vectors in flight -> out_valid drops to 0
//     immediately. After release, no stale result appears. The next vector's latency is LEVELS.
//   6 N=1, W=16: inputs[0]=0x8000 -> 1 cycle later value=0x8000, index=0. Also run a
//     randomized scoreboard against a reference model for N in {1,2,3,7,8}.

Source files
------------

// File: rtl/max_finder_pipe_if.sv
// Streaming handshake bundle for max_finder_pipe: vector in, selected element plus index out.
// The master side produces vectors and consumes results; the slave side is the finder itself.
interface max_finder_pipe_if #(
    parameter int WIDTH      = 8,
    parameter int NUM_INPUTS = 4
);
    localparam int IDX_W = (NUM_INPUTS == 1) ? 1 : $clog2(NUM_INPUTS);

    logic             in_valid;
    logic             in_ready;
    logic             in_min;
    logic [WIDTH-1:0] inputs [NUM_INPUTS];
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_value;
    logic [IDX_W-1:0] out_index;

    modport master (
        output in_valid, in_min, inputs, out_ready,
        input  in_ready, out_valid, out_value, out_index
    );

    modport slave (
        input  in_valid, in_min, inputs, out_ready,
        output in_ready, out_valid, out_value, out_index
    );
endinterface

// File: rtl/max_finder_pipe.sv
// Pipelined max/min finder: one register stage per pairwise tree level, a single global
// advance for backpressure, and results carrying the original element index.
module max_finder_pipe #(
    parameter int WIDTH      = 8,
    parameter int NUM_INPUTS = 4,
    parameter bit SIGNED     = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    max_finder_pipe_if.slave io
);
    localparam int LEVELS = (NUM_INPUTS == 1) ? 1 : $clog2(NUM_INPUTS);
    localparam int IDX_W  = (NUM_INPUTS == 1) ? 1 : $clog2(NUM_INPUTS);

    // Number of live elements entering tree level k.
    function automatic int width_at(input int k);
        return (NUM_INPUTS + (1 << k) - 1) >> k;
    endfunction

    // Left wins ties in both modes so the lowest index is always reported.
    function automatic logic left_wins(input logic [WIDTH-1:0] l,
                                       input logic [WIDTH-1:0] r,
                                       input logic             mn);
        logic signed [WIDTH:0] ls;
        logic signed [WIDTH:0] rs;
        ls = SIGNED ? {l[WIDTH-1], l} : {1'b0, l};
        rs = SIGNED ? {r[WIDTH-1], r} : {1'b0, r};
        return mn ? (ls <= rs) : (ls >= rs);
    endfunction

    logic              adv;
    logic [LEVELS-1:0] vld_p;
    logic [LEVELS-1:0] min_p;
    logic [LEVELS-1:0] src_min;
    logic [WIDTH-1:0]  src_val [LEVELS][NUM_INPUTS];
    logic [IDX_W-1:0]  src_idx [LEVELS][NUM_INPUTS];
    logic [WIDTH-1:0]  nxt_val [LEVELS][NUM_INPUTS];
    logic [IDX_W-1:0]  nxt_idx [LEVELS][NUM_INPUTS];
    logic [WIDTH-1:0]  val_p   [LEVELS][NUM_INPUTS];
    logic [IDX_W-1:0]  idx_p   [LEVELS][NUM_INPUTS];

    assign adv         = !vld_p[LEVELS-1] || io.out_ready;
    assign io.in_ready = adv;

    for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
        localparam int CIN  = width_at(k);
        localparam int COUT = width_at(k + 1);

        if (k == 0) begin : g_src_in
            assign src_min[k] = io.in_min;
            for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_e
                assign src_val[k][i] = io.inputs[i];
                assign src_idx[k][i] = IDX_W'(i);
            end
        end else begin : g_src_reg
            assign src_min[k] = min_p[k-1];
            for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_e
                assign src_val[k][i] = val_p[k-1][i];
                assign src_idx[k][i] = idx_p[k-1][i];
            end
        end

        for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_node
            if (i >= COUT) begin : g_idle
                assign nxt_val[k][i] = '0;
                assign nxt_idx[k][i] = '0;
            end else if (2 * i + 1 < CIN) begin : g_cmp
                logic take_l;
                assign take_l        = left_wins(src_val[k][2*i], src_val[k][2*i+1], src_min[k]);
                assign nxt_val[k][i] = take_l ? src_val[k][2*i] : src_val[k][2*i+1];
                assign nxt_idx[k][i] = take_l ? src_idx[k][2*i] : src_idx[k][2*i+1];
            end else begin : g_pass
                assign nxt_val[k][i] = src_val[k][2*i];
                assign nxt_idx[k][i] = src_idx[k][2*i];
            end
        end
    end

    // Stage registers: every level shifts together on adv and holds otherwise.
    always_ff @(posedge clk) begin
        if (adv) begin
            for (int k = 0; k < LEVELS; k++) begin
                min_p[k] <= src_min[k];
                for (int i = 0; i < NUM_INPUTS; i++) begin
                    val_p[k][i] <= nxt_val[k][i];
                    idx_p[k][i] <= nxt_idx[k][i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p <= '0;
        end else if (adv) begin
            vld_p <= LEVELS'({vld_p, io.in_valid});
        end
    end

    // Result is forced to zero whenever no result is presented, covering the reset state.
    assign io.out_valid = vld_p[LEVELS-1];
    assign io.out_value = vld_p[LEVELS-1] ? val_p[LEVELS-1][0] : '0;
    assign io.out_index = vld_p[LEVELS-1] ? idx_p[LEVELS-1][0] : '0;
endmodule

// File: tb/tb_max_finder_pipe.sv
// Directed and randomized checks of max_finder_pipe across several widths, sizes and sign modes.
module tb_max_finder_pipe;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    max_finder_pipe_if #(.WIDTH(8),  .NUM_INPUTS(4)) if4s ();
    max_finder_pipe_if #(.WIDTH(8),  .NUM_INPUTS(4)) if4u ();
    max_finder_pipe_if #(.WIDTH(8),  .NUM_INPUTS(5)) if5 ();
    max_finder_pipe_if #(.WIDTH(16), .NUM_INPUTS(1)) if1 ();

    max_finder_pipe #(.WIDTH(8),  .NUM_INPUTS(4), .SIGNED(1'b1)) u4s (.clk(clk), .rst_n(rst_n), .io(if4s.slave));
    max_finder_pipe #(.WIDTH(8),  .NUM_INPUTS(4), .SIGNED(1'b0)) u4u (.clk(clk), .rst_n(rst_n), .io(if4u.slave));
    max_finder_pipe #(.WIDTH(8),  .NUM_INPUTS(5), .SIGNED(1'b1)) u5  (.clk(clk), .rst_n(rst_n), .io(if5.slave));
    max_finder_pipe #(.WIDTH(16), .NUM_INPUTS(1), .SIGNED(1'b1)) u1  (.clk(clk), .rst_n(rst_n), .io(if1.slave));

    // Randomized instances share one stimulus vector; instance g uses its first N elements.
    logic       r_in_valid = 1'b0;
    logic       r_in_min = 1'b0;
    logic       r_out_ready = 1'b1;
    logic [7:0] stim [8];
    logic [4:0] r_in_ready;
    logic [4:0] r_out_valid;
    logic [7:0] r_out_value [5];
    logic [2:0] r_out_index [5];
    int         nlist [5] = '{1, 2, 3, 7, 8};
    logic [10:0] exq [5][$];

    for (genvar g = 0; g < 5; g++) begin : rnd
        localparam int N = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 3 : (g == 3) ? 7 : 8;
        max_finder_pipe_if #(.WIDTH(8), .NUM_INPUTS(N)) rif ();
        max_finder_pipe #(.WIDTH(8), .NUM_INPUTS(N), .SIGNED(1'b1)) u (.clk(clk), .rst_n(rst_n), .io(rif.slave));
        assign rif.in_valid   = r_in_valid;
        assign rif.in_min     = r_in_min;
        assign rif.out_ready  = r_out_ready;
        for (genvar i = 0; i < N; i++) begin : g_in
            assign rif.inputs[i] = stim[i];
        end
        assign r_in_ready[g]  = rif.in_ready;
        assign r_out_valid[g] = rif.out_valid;
        assign r_out_value[g] = rif.out_value;
        assign r_out_index[g] = 3'(rif.out_index);
    end

    logic [7:0] bp_vec [6][4] = '{'{8'h01, 8'h02, 8'h03, 8'h04}, '{8'hFF, 8'hFE, 8'hFD, 8'hFC},
                                  '{8'h05, 8'h05, 8'h05, 8'h05}, '{8'h00, 8'h64, 8'h9C, 8'h32},
                                  '{8'h80, 8'h7F, 8'h00, 8'h00}, '{8'h07, 8'h08, 8'h08, 8'h07}};
    logic [7:0] bp_exp_val [6] = '{8'h04, 8'hFF, 8'h05, 8'h64, 8'h7F, 8'h08};
    logic [1:0] bp_exp_idx [6] = '{2'd3, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1};

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive4s(input logic v, input logic mn, input logic [7:0] a, b, c, d);
        if4s.in_valid = v; if4s.in_min = mn;
        if4s.inputs[0] = a; if4s.inputs[1] = b; if4s.inputs[2] = c; if4s.inputs[3] = d;
    endtask

    task automatic drive4u(input logic v, input logic mn, input logic [7:0] a, b, c, d);
        if4u.in_valid = v; if4u.in_min = mn;
        if4u.inputs[0] = a; if4u.inputs[1] = b; if4u.inputs[2] = c; if4u.inputs[3] = d;
    endtask

    task automatic drive5(input logic v, input logic [7:0] a, b, c, d, e);
        if5.in_valid = v; if5.in_min = 1'b0;
        if5.inputs[0] = a; if5.inputs[1] = b; if5.inputs[2] = c; if5.inputs[3] = d; if5.inputs[4] = e;
    endtask

    // Linear-scan reference: strict comparison keeps the first (lowest-index) extreme element.
    function automatic logic [10:0] ref_sel(input int n, input logic mn);
        int best = 0;
        for (int i = 1; i < n; i++) begin
            if (mn ? ($signed(stim[i]) < $signed(stim[best])) : ($signed(stim[i]) > $signed(stim[best])))
                best = i;
        end
        return {3'(best), stim[best]};
    endfunction

    task automatic rnd_step();
        logic [10:0] e;
        #1;
        for (int g = 0; g < 5; g++) begin
            if (r_out_valid[g] && r_out_ready) begin
                if (exq[g].size() == 0) begin
                    chk($sformatf("rnd_spurious_n%0d", nlist[g]), 32'(r_out_valid[g]), 32'd0);
                end else begin
                    e = exq[g].pop_front();
                    chk($sformatf("rnd_n%0d", nlist[g]), 32'({r_out_index[g], r_out_value[g]}), 32'(e));
                end
            end
            if (r_in_valid && r_in_ready[g]) exq[g].push_back(ref_sel(nlist[g], r_in_min));
        end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int vi, ri;
        logic held;
        logic [7:0] held_val;
        logic [1:0] held_idx;

        drive4s(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
        drive4u(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
        drive5(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        if1.in_valid = 1'b0; if1.in_min = 1'b0; if1.inputs[0] = 16'h0000;
        if4s.out_ready = 1'b1; if4u.out_ready = 1'b1; if5.out_ready = 1'b1; if1.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) stim[i] = 8'h00;

        // Reset state
        tick(); tick();
        chk("rst_out_valid", 32'(if4s.out_valid), 32'd0);
        chk("rst_out_value", 32'(if4s.out_value), 32'd0);
        chk("rst_out_index", 32'(if4s.out_index), 32'd0);
        chk("rst_in_ready", 32'(if4s.in_ready), 32'd1);
        if4s.out_ready = 1'b0; #1;
        chk("idle_in_ready_no_out_ready", 32'(if4s.in_ready), 32'd1);
        if4s.out_ready = 1'b1;
        rst_n = 1'b1;
        tick();

        // Signed max then signed min; unsigned min of the same bits
        drive4s(1'b1, 1'b0, 8'h03, 8'hF9, 8'h0C, 8'h0C);
        drive4u(1'b1, 1'b1, 8'h03, 8'hF9, 8'h0C, 8'h0C);
        tick();
        drive4s(1'b1, 1'b1, 8'h03, 8'hF9, 8'h0C, 8'h0C);
        if4u.in_valid = 1'b0;
        chk("t1_latency_not_yet", 32'(if4s.out_valid), 32'd0);
        tick();
        if4s.in_valid = 1'b0;
        chk("t1_valid", 32'(if4s.out_valid), 32'd1);
        chk("t1_max_value", 32'(if4s.out_value), 32'h0C);
        chk("t1_max_index", 32'(if4s.out_index), 32'd2);
        chk("t2u_valid", 32'(if4u.out_valid), 32'd1);
        chk("t2u_min_value", 32'(if4u.out_value), 32'h03);
        chk("t2u_min_index", 32'(if4u.out_index), 32'd0);
        tick();
        chk("t2_valid", 32'(if4s.out_valid), 32'd1);
        chk("t2_min_value", 32'(if4s.out_value), 32'hF9);
        chk("t2_min_index", 32'(if4s.out_index), 32'd1);
        chk("t2u_done", 32'(if4u.out_valid), 32'd0);
        tick();
        chk("t2_done", 32'(if4s.out_valid), 32'd0);

        // Odd-sized tree, back-to-back vectors
        drive5(1'b1, 8'd1, 8'd9, 8'd4, 8'd2, 8'd20);
        tick();
        drive5(1'b1, 8'd30, 8'd0, 8'd0, 8'd0, 8'd0);
        tick();
        if5.in_valid = 1'b0;
        chk("t3_not_yet", 32'(if5.out_valid), 32'd0);
        tick();
        chk("t3a_valid", 32'(if5.out_valid), 32'd1);
        chk("t3a_value", 32'(if5.out_value), 32'd20);
        chk("t3a_index", 32'(if5.out_index), 32'd4);
        tick();
        chk("t3b_valid", 32'(if5.out_valid), 32'd1);
        chk("t3b_value", 32'(if5.out_value), 32'd30);
        chk("t3b_index", 32'(if5.out_index), 32'd0);
        tick();
        chk("t3_done", 32'(if5.out_valid), 32'd0);

        // Single-element instance
        if1.in_valid = 1'b1; if1.in_min = 1'b0; if1.inputs[0] = 16'h8000;
        tick();
        if1.in_valid = 1'b1; if1.in_min = 1'b1; if1.inputs[0] = 16'h1234;
        chk("t6_valid", 32'(if1.out_valid), 32'd1);
        chk("t6_value", 32'(if1.out_value), 32'h8000);
        chk("t6_index", 32'(if1.out_index), 32'd0);
        tick();
        if1.in_valid = 1'b0;
        chk("t6b_value", 32'(if1.out_value), 32'h1234);
        tick();
        chk("t6_done", 32'(if1.out_valid), 32'd0);

        // Backpressure: consumer stalls for four cycles mid-stream
        vi = 0; ri = 0; held = 1'b0; held_val = '0; held_idx = '0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if4s.out_ready = !(cyc >= 3 && cyc < 7);
            if (vi < 6) drive4s(1'b1, 1'b0, bp_vec[vi][0], bp_vec[vi][1], bp_vec[vi][2], bp_vec[vi][3]);
            else if4s.in_valid = 1'b0;
            #1;
            if (held) begin
                chk("bp_hold_value", 32'(if4s.out_value), 32'(held_val));
                chk("bp_hold_index", 32'(if4s.out_index), 32'(held_idx));
                held = 1'b0;
            end
            if (if4s.out_valid && !if4s.out_ready) begin
                chk("bp_in_ready_low", 32'(if4s.in_ready), 32'd0);
                held = 1'b1; held_val = if4s.out_value; held_idx = if4s.out_index;
            end
            if (if4s.out_valid && if4s.out_ready) begin
                if (ri < 6) begin
                    chk($sformatf("bp_value_%0d", ri), 32'(if4s.out_value), 32'(bp_exp_val[ri]));
                    chk($sformatf("bp_index_%0d", ri), 32'(if4s.out_index), 32'(bp_exp_idx[ri]));
                end else begin
                    chk("bp_extra_result", 32'(if4s.out_valid), 32'd0);
                end
                ri++;
            end
            if (if4s.in_valid && if4s.in_ready) vi++;
            tick();
        end
        chk("bp_result_count", 32'(ri), 32'd6);
        chk("bp_accept_count", 32'(vi), 32'd6);

        // Reset with two vectors in flight
        if4s.out_ready = 1'b1;
        drive4s(1'b1, 1'b0, 8'h11, 8'h22, 8'h33, 8'h44);
        tick();
        drive4s(1'b1, 1'b0, 8'h55, 8'h01, 8'h01, 8'h01);
        tick();
        if4s.in_valid = 1'b0;
        chk("t5_pre_valid", 32'(if4s.out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t5_async_valid", 32'(if4s.out_valid), 32'd0);
        chk("t5_async_value", 32'(if4s.out_value), 32'd0);
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("t5_no_stale", 32'(if4s.out_valid), 32'd0);
        end
        drive4s(1'b1, 1'b0, 8'h09, 8'h01, 8'h02, 8'h03);
        tick();
        if4s.in_valid = 1'b0;
        chk("t5_post_not_yet", 32'(if4s.out_valid), 32'd0);
        tick();
        chk("t5_post_valid", 32'(if4s.out_valid), 32'd1);
        chk("t5_post_value", 32'(if4s.out_value), 32'h09);
        chk("t5_post_index", 32'(if4s.out_index), 32'd0);

        // Randomized traffic with random stalls on N = 1, 2, 3, 7, 8
        for (int c = 0; c < 400; c++) begin
            r_in_valid  = ($urandom_range(0, 3) != 0);
            r_in_min    = 1'($urandom_range(0, 1));
            r_out_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 8; i++) stim[i] = ($urandom_range(0, 7) == 0) ? 8'h80 : 8'($urandom_range(0, 255));
            rnd_step();
        end
        r_in_valid = 1'b0;
        r_out_ready = 1'b1;
        for (int c = 0; c < 6; c++) rnd_step();
        for (int g = 0; g < 5; g++) chk($sformatf("rnd_drain_n%0d", nlist[g]), 32'(exq[g].size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
